decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
- Registered, pipelined successor to the combinational decode stage.
- Accepts fetched instructions over a valid/ready handshake and decodes them with the existing control_unit and sign_extend encodings.
- Holds the result in an ID/EX output register with backpressure.
- Adds load-use hazard stalling, a synchronous flush for taken branches and jumps, illegal-opcode detection, and an optional RV32M decode mode.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width.
- ADDR_WIDTH, 32, PC width carried alongside the instruction.
- LOAD_USE_BUBBLES, 1, number of cycles a dependent instruction is held after a load issues (0 disables hazard stalling).
- M_EXT, 0, 1 = decode OP funct7=0000001 as MUL/DIV (ALUctrl 4'b1000+funct3[1:0] region reserved); 0 = flag such instructions as illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  decode accepts this cycle.
- instr  in  DATA_WIDTH  instruction word.
- pc  in  ADDR_WIDTH  instruction address.
- flush  in  1  discard the held and incoming instruction (branch/jump resolved).
- out_valid  out  1  ID/EX register holds a valid decoded instruction.
- out_ready  in  1  execute consumes this cycle.
- out_pc  out  ADDR_WIDTH  registered pc.
- RegWrite, MemWrite, MemRead, ALUSrc, PcOp  out  1 each  registered control bits.
- ALUctrl  out  4  registered ALU control.
- ResultSrc  out  2  registered result select.
- ImmExt  out  DATA_WIDTH  registered sign-extended immediate.
- rs1, rs2, rd  out  5 each  registered register indices.
- illegal  out  1  registered: opcode unsupported.

Behaviour:
- Reset, asynchronous:
  - out_valid=0 and every registered output = 0.
  - Hazard counter = 0, pending rd = 0.
  - in_ready is driven combinationally after reset release.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Issue when out_valid & out_ready.
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Latency: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1. Full throughput is one instruction per cycle when there is no hazard.
- Hold: while out_valid & !out_ready, all outputs stay stable.
- Decode on accept:
  - Control bits follow the existing control_unit mapping; ImmExt follows sign_extend on instr[31:7].
  - PCSrc is not produced here, because branch resolution moves to execute.
- Illegal:
  - Triggered by an opcode outside {03,13,17,23,33,37,63,67,6F}, or by M-type when M_EXT=0.
  - Result: illegal=1, RegWrite=0, MemWrite=0, MemRead=0. The instruction is still issued normally.
- Load-use hazard (LOAD_USE_BUBBLES>0):
  - When an instruction with MemRead=1 and rd!=0 issues, latch pending_rd=rd and load counter=LOAD_USE_BUBBLES.
  - hazard = counter!=0 & in_valid & (instr rs1==pending_rd | (instr uses rs2 & instr rs2==pending_rd)). rs2 is used by opcodes 33, 23 and 63.
  - The counter decrements every cycle while nonzero.
  - No bubble is inserted into the output. out_valid simply drops because nothing is accepted.
- Flush (synchronous, highest priority):
  - next out_valid=0, counter=0, and the incoming instruction is not accepted (in_ready=0).
  - If out_ready is high in the same cycle, the current output still counts as issued.
- Simultaneous issue and accept: the register reloads with the new instruction, and out_valid stays 1.
- Reset mid-stall or mid-hold: all state clears immediately, with no residual hazard.
- x0: rd=0 never creates a hazard, and a load to x0 leaves the counter untouched.

Test Plan:
- Reset, then in_valid with instr=0x00C08293 (addi x5,x1,12) and pc=0x100 → next cycle: out_valid=1, rd=5, rs1=1, ImmExt=0x0000000C, ALUSrc=1, RegWrite=1, illegal=0, out_pc=0x100.
- Back-to-back 0x0002A303 (lw x6,0(x5)) then 0x001303B3 (add x7,x6,x1), out_ready=1 throughout → lw issues; add is held with in_ready=0 for exactly 1 cycle, then issues with rs1=6, rs2=1. Repeat with LOAD_USE_BUBBLES=0 → no stall.
- out_ready=0 for 3 cycles with out_valid=1 → outputs unchanged and in_ready=0. Then out_ready=1 with in_valid=1 → new instruction loaded the next cycle with no gap.
- flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0 and the incoming instruction is dropped. Flush during a load-use stall → counter cleared, and the dependent instruction is accepted the following cycle.
- instr=0x0000007F, and instr=0x022081B3 (mul) with M_EXT=0 → illegal=1, RegWrite=0. The same mul with M_EXT=1 → illegal=0.
- rst pulsed asynchronously mid-cycle during a hazard stall → out_valid=0 immediately, and in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/decode_pipe.sv
// Pipelined instruction decode stage: valid/ready fetch input, ID/EX output register with
// backpressure, load-use hazard stalling, synchronous flush and illegal-opcode detection.
module decode_pipe #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned M_EXT            = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  ALUSrc,
  output logic                  PcOp,
  output logic [3:0]            ALUctrl,
  output logic [1:0]            ResultSrc,
  output logic [DATA_WIDTH-1:0] ImmExt,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  illegal
);

  localparam int unsigned CNT_W = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES) + 1 : 1;
  // The cycle the load spends in ID/EX is the first bubble; the counter covers the rest.
  localparam logic [CNT_W-1:0] CNT_RELOAD =
    CNT_W'((LOAD_USE_BUBBLES > 0) ? LOAD_USE_BUBBLES - 1 : 0);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  alu_src;
    logic                  pc_op;
    logic [3:0]            alu_ctrl;
    logic [1:0]            result_src;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  illegal;
  } idex_t;

  function automatic logic [31:0] sign_extend(input logic [31:7] v, input imm_sel_e sel);
    logic [31:0] r;
    case (sel)
      IMM_I:   r = {{20{v[31]}}, v[31:20]};
      IMM_S:   r = {{20{v[31]}}, v[31:25], v[11:7]};
      IMM_B:   r = {{19{v[31]}}, v[31], v[7], v[30:25], v[11:8], 1'b0};
      IMM_U:   r = {v[31:12], 12'b0};
      IMM_J:   r = {{11{v[31]}}, v[31], v[19:12], v[20], v[30:21], 1'b0};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  // sub_sra selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub_sra);
    logic [3:0] r;
    case (f3)
      3'b000:  r = sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [4:0]       w_in_rs1;
  logic [4:0]       w_in_rs2;
  logic             w_uses_rs2;
  imm_sel_e         w_imm_sel;
  idex_t            w_dec;
  logic             w_head_hz;
  logic             w_cnt_hz;
  logic             w_hazard;
  logic             w_accept;
  logic             w_issue;
  logic             w_load_issue;

  idex_t            r_q;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pend_rd;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_funct7   = instr[31:25];
  assign w_in_rs1   = instr[19:15];
  assign w_in_rs2   = instr[24:20];
  assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BR);

  // Control decode of the incoming instruction
  always_comb begin
    w_dec     = '0;
    w_imm_sel = IMM_NONE;
    w_dec.pc  = pc;
    w_dec.rs1 = w_in_rs1;
    w_dec.rs2 = w_in_rs2;
    w_dec.rd  = instr[11:7];
    case (w_opcode)
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.result_src = 2'b01;
        w_imm_sel        = IMM_I;
      end
      OP_IMM: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctrl  = alu_dec(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        w_imm_sel       = IMM_I;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_imm_sel       = IMM_U;
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_imm_sel       = IMM_S;
      end
      OP_REG: begin
        w_dec.reg_write = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          if (M_EXT != 0) w_dec.alu_ctrl = {2'b10, w_funct3[1:0]};
          else            w_dec.illegal  = 1'b1;
        end else begin
          w_dec.alu_ctrl = alu_dec(w_funct3, w_funct7[5]);
        end
      end
      OP_LUI: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b11;
        w_imm_sel        = IMM_U;
      end
      OP_BR: begin
        w_dec.pc_op    = 1'b1;
        w_dec.alu_ctrl = ALU_SUB;
        w_imm_sel      = IMM_B;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.pc_op      = 1'b1;
        w_dec.result_src = 2'b10;
        w_imm_sel        = IMM_I;
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.pc_op      = 1'b1;
        w_dec.result_src = 2'b10;
        w_imm_sel        = IMM_J;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.imm = DATA_WIDTH'($signed(sign_extend(instr[31:7], w_imm_sel)));
    if (w_dec.illegal) begin
      w_dec.reg_write = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.mem_read  = 1'b0;
    end
  end

  // Load-use hazard: a load still in ID/EX, or one that left within the bubble window
  always_comb begin
    w_head_hz = r_valid && r_q.mem_read && (r_q.rd != 5'd0) &&
                ((w_in_rs1 == r_q.rd) || (w_uses_rs2 && (w_in_rs2 == r_q.rd)));
    w_cnt_hz  = (r_cnt != '0) &&
                ((w_in_rs1 == r_pend_rd) || (w_uses_rs2 && (w_in_rs2 == r_pend_rd)));
    w_hazard  = (LOAD_USE_BUBBLES != 0) && in_valid && (w_head_hz || w_cnt_hz);
  end

  assign in_ready     = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept     = in_valid && in_ready;
  assign w_issue      = r_valid && out_ready;
  assign w_load_issue = w_issue && r_q.mem_read && (r_q.rd != 5'd0) && (LOAD_USE_BUBBLES != 0);

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else begin
      if (w_accept) r_q <= w_dec;
      if (flush)         r_valid <= 1'b0;
      else if (w_accept) r_valid <= 1'b1;
      else if (w_issue)  r_valid <= 1'b0;
    end
  end

  // Bubble counter and the destination of the load that armed it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pend_rd <= 5'd0;
    end else if (flush) begin
      r_cnt     <= '0;
    end else if (w_load_issue) begin
      r_cnt     <= CNT_RELOAD;
      r_pend_rd <= r_q.rd;
    end else if (r_cnt != '0) begin
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_q.pc;
  assign RegWrite  = r_q.reg_write;
  assign MemWrite  = r_q.mem_write;
  assign MemRead   = r_q.mem_read;
  assign ALUSrc    = r_q.alu_src;
  assign PcOp      = r_q.pc_op;
  assign ALUctrl   = r_q.alu_ctrl;
  assign ResultSrc = r_q.result_src;
  assign ImmExt    = r_q.imm;
  assign rs1       = r_q.rs1;
  assign rs2       = r_q.rs2;
  assign rd        = r_q.rd;
  assign illegal   = r_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe; three instances cover LOAD_USE_BUBBLES=1/0/3 and M_EXT=0/1.
module tb_decode_pipe;

  localparam int N = 3;
  localparam logic [31:0] ADDI   = 32'h00C08293;  // addi x5,x1,12
  localparam logic [31:0] LW     = 32'h0002A303;  // lw x6,0(x5)
  localparam logic [31:0] ADD    = 32'h001303B3;  // add x7,x6,x1
  localparam logic [31:0] LW_X0  = 32'h0002A003;  // lw x0,0(x5)
  localparam logic [31:0] ADD_X0 = 32'h001003B3;  // add x7,x0,x1
  localparam logic [31:0] LUI    = 32'h12345537;  // lui x10,0x12345
  localparam logic [31:0] BAD    = 32'h0000007F;
  localparam logic [31:0] MUL    = 32'h022081B3;  // mul x3,x1,x2

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr, pc;
  logic        in_ready [N];
  logic        out_valid[N];
  logic        reg_write[N];
  logic        mem_write[N];
  logic        mem_read [N];
  logic        alu_src  [N];
  logic        pc_op    [N];
  logic        illegal  [N];
  logic [31:0] out_pc   [N];
  logic [31:0] imm      [N];
  logic [3:0]  alu_ctrl [N];
  logic [1:0]  res_src  [N];
  logic [4:0]  rs1_o    [N];
  logic [4:0]  rs2_o    [N];
  logic [4:0]  rd_o     [N];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    decode_pipe #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32),
      .LOAD_USE_BUBBLES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .M_EXT((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
      .instr(instr), .pc(pc), .flush(flush),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_pc(out_pc[g]),
      .RegWrite(reg_write[g]), .MemWrite(mem_write[g]), .MemRead(mem_read[g]),
      .ALUSrc(alu_src[g]), .PcOp(pc_op[g]), .ALUctrl(alu_ctrl[g]),
      .ResultSrc(res_src[g]), .ImmExt(imm[g]),
      .rs1(rs1_o[g]), .rs2(rs2_o[g]), .rd(rd_o[g]), .illegal(illegal[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    in_valid = v;
    instr    = i;
    pc       = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_out_valid", 32'(out_valid[g]), 32'h0);
      chk("rst_imm", imm[g], 32'h0);
    end
    chk("rst_rd", 32'(rd_o[0]), 32'h0);
    chk("rst_regwrite", 32'(reg_write[0]), 32'h0);
    step();
    rst = 1'b0;

    // addi x5,x1,12
    drive(1'b1, ADDI, 32'h100);
    @(negedge clk); chk("addi_in_ready", 32'(in_ready[0]), 32'h1);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("addi_valid", 32'(out_valid[0]), 32'h1);
    chk("addi_rd", 32'(rd_o[0]), 32'd5);
    chk("addi_rs1", 32'(rs1_o[0]), 32'd1);
    chk("addi_imm", imm[0], 32'h0000000C);
    chk("addi_alusrc", 32'(alu_src[0]), 32'h1);
    chk("addi_regwrite", 32'(reg_write[0]), 32'h1);
    chk("addi_illegal", 32'(illegal[0]), 32'h0);
    chk("addi_pc", out_pc[0], 32'h100);
    step();

    // lw x6 followed by dependent add x7,x6,x1
    drive(1'b1, LW, 32'h104);
    @(negedge clk); chk("lw_in_ready", 32'(in_ready[0]), 32'h1);
    step(); drive(1'b1, ADD, 32'h108);
    @(negedge clk);
    chk("lw_valid", 32'(out_valid[0]), 32'h1);
    chk("lw_memread", 32'(mem_read[0]), 32'h1);
    chk("lw_memwrite", 32'(mem_write[0]), 32'h0);
    chk("lw_rd", 32'(rd_o[0]), 32'd6);
    chk("lw_ressrc", 32'(res_src[0]), 32'h1);
    chk("hz_stall", 32'(in_ready[0]), 32'h0);
    chk("hz_nostall_b0", 32'(in_ready[1]), 32'h1);
    chk("hz_stall_b3", 32'(in_ready[2]), 32'h0);
    step();
    @(negedge clk);
    chk("hz_gap_valid", 32'(out_valid[0]), 32'h0);
    chk("hz_release", 32'(in_ready[0]), 32'h1);
    chk("b0_add_valid", 32'(out_valid[1]), 32'h1);
    chk("b0_add_rd", 32'(rd_o[1]), 32'd7);
    chk("b3_still_stall", 32'(in_ready[2]), 32'h0);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid[0]), 32'h1);
    chk("add_rs1", 32'(rs1_o[0]), 32'd6);
    chk("add_rs2", 32'(rs2_o[0]), 32'd1);
    chk("add_rd", 32'(rd_o[0]), 32'd7);
    chk("add_pc", out_pc[0], 32'h108);
    chk("add_alu", 32'(alu_ctrl[0]), 32'h0);
    chk("add_pcop", 32'(pc_op[0]), 32'h0);
    step(); step(); step();

    // backpressure hold then back-to-back reload
    out_ready = 1'b0;
    drive(1'b1, ADDI, 32'h200);
    @(negedge clk); chk("bp_in_ready", 32'(in_ready[0]), 32'h1);
    step(); drive(1'b1, LUI, 32'h204);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid[0]), 32'h1);
      chk("hold_pc", out_pc[0], 32'h200);
      chk("hold_imm", imm[0], 32'h0000000C);
      chk("hold_in_ready", 32'(in_ready[0]), 32'h0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_resume_ready", 32'(in_ready[0]), 32'h1);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("lui_valid", 32'(out_valid[0]), 32'h1);
    chk("lui_pc", out_pc[0], 32'h204);
    chk("lui_rd", 32'(rd_o[0]), 32'd10);
    chk("lui_imm", imm[0], 32'h12345000);
    chk("lui_ressrc", 32'(res_src[0]), 32'h3);
    step();

    // flush with held and incoming instruction
    drive(1'b1, ADDI, 32'h300);
    step(); drive(1'b1, LUI, 32'h304); flush = 1'b1;
    @(negedge clk);
    chk("fl_valid_before", 32'(out_valid[0]), 32'h1);
    chk("fl_in_ready", 32'(in_ready[0]), 32'h0);
    step(); flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
    @(negedge clk); chk("fl_valid_after", 32'(out_valid[0]), 32'h0);
    step();
    @(negedge clk); chk("fl_dropped", 32'(out_valid[0]), 32'h0);
    step();

    // flush during a load-use stall on the 3-bubble instance
    drive(1'b1, LW, 32'h400);
    step(); drive(1'b1, ADD, 32'h404);
    @(negedge clk); chk("fs_stall_head", 32'(in_ready[2]), 32'h0);
    step(); flush = 1'b1;
    @(negedge clk); chk("fs_stall_cnt", 32'(in_ready[2]), 32'h0);
    step(); flush = 1'b0;
    @(negedge clk); chk("fs_cleared", 32'(in_ready[2]), 32'h1);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("fs_add_valid", 32'(out_valid[2]), 32'h1);
    chk("fs_add_rd", 32'(rd_o[2]), 32'd7);
    chk("fs_add_pc", out_pc[2], 32'h404);
    step();

    // load to x0 never stalls
    drive(1'b1, LW_X0, 32'h480);
    step(); drive(1'b1, ADD_X0, 32'h484);
    @(negedge clk); chk("x0_no_stall", 32'(in_ready[2]), 32'h1);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("x0_add_valid", 32'(out_valid[2]), 32'h1);
    chk("x0_add_pc", out_pc[2], 32'h484);
    step(); step();

    // asynchronous reset in the middle of a stall
    drive(1'b1, LW, 32'h500);
    step(); drive(1'b1, ADD, 32'h504);
    step();
    chk("pre_rst_valid_b0", 32'(out_valid[1]), 32'h1);
    chk("pre_rst_stall_b3", 32'(in_ready[2]), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid_b0", 32'(out_valid[1]), 32'h0);
    chk("rst_async_valid_b3", 32'(out_valid[2]), 32'h0);
    chk("rst_async_rd_b0", 32'(rd_o[1]), 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_release_ready", 32'(in_ready[2]), 32'h1);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_add_valid", 32'(out_valid[2]), 32'h1);
    chk("rst_add_rd", 32'(rd_o[2]), 32'd7);
    step();

    // illegal opcode, then mul with and without M decode
    drive(1'b1, BAD, 32'h600);
    step(); drive(1'b1, MUL, 32'h604);
    @(negedge clk);
    chk("bad_valid", 32'(out_valid[0]), 32'h1);
    chk("bad_illegal", 32'(illegal[0]), 32'h1);
    chk("bad_regwrite", 32'(reg_write[0]), 32'h0);
    step(); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mul_m0_valid", 32'(out_valid[0]), 32'h1);
    chk("mul_m0_illegal", 32'(illegal[0]), 32'h1);
    chk("mul_m0_regwrite", 32'(reg_write[0]), 32'h0);
    chk("mul_m1_illegal", 32'(illegal[1]), 32'h0);
    chk("mul_m1_regwrite", 32'(reg_write[1]), 32'h1);
    chk("mul_m1_alu", 32'(alu_ctrl[1]), 32'h8);
    chk("mul_m1_rd", 32'(rd_o[1]), 32'd3);
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
